// File: rtl/conv_sched.sv
// Convolution scheduler: loads a frame of SIZE_X samples, then sequences SIZE_F-tap
// MAC passes (clear, run, drain, output) for each of the SIZE_X-SIZE_F+1 output points.
module conv_sched #(
    parameter int SIZE_X  = 32,
    parameter int SIZE_F  = 4,
    parameter int MAC_LAT = 3,
    localparam int AXW = $clog2(SIZE_X),
    localparam int AFW = (SIZE_F > 1) ? $clog2(SIZE_F) : 1,
    localparam int YW  = $clog2(SIZE_X - SIZE_F + 2)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           x_valid,
    output logic           x_ready,
    output logic           wr_en_x,
    output logic [AXW-1:0] addr_x,
    output logic [AFW-1:0] addr_f,
    output logic           clear_acc,
    output logic           en_acc,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [YW-1:0]  y_index,
    output logic           busy,
    output logic [2:0]     dbg_state
);

    // Handshakes: a sample transfers on a rising edge with x_valid & x_ready high; a point
    // transfers on a rising edge with y_valid & y_ready high. Valid/ready never wait on each other.

    localparam int DW = $clog2(MAC_LAT + 2);
    localparam logic [AXW-1:0] LAST_X = AXW'(SIZE_X - 1);
    localparam logic [AXW-1:0] LAST_B = AXW'(SIZE_X - SIZE_F);
    localparam logic [AFW-1:0] LAST_F = AFW'(SIZE_F - 1);
    localparam logic [DW-1:0]  LAST_D = DW'(MAC_LAT);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t         state, state_nxt;
    logic [AXW-1:0] load_cnt;
    logic [AXW-1:0] base;
    logic [AFW-1:0] tap;
    logic [DW-1:0]  drain_cnt;
    logic [YW-1:0]  y_index_q;
    logic           en_acc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD:  if (x_valid && load_cnt == LAST_X) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = S_RUN;
            S_RUN:   if (tap == LAST_F) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == LAST_D) state_nxt = S_OUT;
            S_OUT:   if (y_ready) state_nxt = (base == LAST_B) ? S_LOAD : S_CLEAR;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_cnt  <= '0;
            base      <= '0;
            tap       <= '0;
            drain_cnt <= '0;
            y_index_q <= '0;
            en_acc_q  <= 1'b0;
        end else begin
            // MAC sees the read data one cycle after the address, so enable trails RUN by one.
            en_acc_q <= (state == S_RUN);
            case (state)
                S_LOAD: begin
                    if (x_valid) begin
                        if (load_cnt == LAST_X) begin
                            load_cnt <= '0;
                            base     <= '0;
                        end else begin
                            load_cnt <= load_cnt + AXW'(1);
                        end
                    end
                end
                S_CLEAR: begin
                    tap <= '0;
                end
                S_RUN: begin
                    // Tap holds at its last value so it never wraps past SIZE_F-1.
                    if (tap != LAST_F) tap <= tap + AFW'(1);
                    drain_cnt <= '0;
                end
                S_DRAIN: begin
                    if (drain_cnt != LAST_D) drain_cnt <= drain_cnt + DW'(1);
                end
                S_OUT: begin
                    if (y_ready) begin
                        if (base == LAST_B) begin
                            base      <= '0;
                            y_index_q <= '0;
                        end else begin
                            base      <= base + AXW'(1);
                            y_index_q <= y_index_q + YW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        x_ready   = (state == S_LOAD);
        wr_en_x   = x_valid & (state == S_LOAD);
        addr_x    = base;
        addr_f    = '0;
        if (state == S_LOAD) begin
            addr_x = load_cnt;
        end else if (state == S_RUN) begin
            addr_x = base + AXW'(tap);
            addr_f = tap;
        end
        // The accumulator is held cleared while reset is asserted.
        clear_acc = (state == S_CLEAR) | ~reset;
        en_acc    = en_acc_q;
        y_valid   = (state == S_OUT);
        y_index   = y_index_q;
        busy      = (state != S_LOAD);
        dbg_state = state;
    end

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: default 32/4/3 instance driven through full frames, stalls and a
// mid-frame reset, plus a 4/4 instance producing a single point per frame.
module tb_conv_sched;

    logic       clk;
    logic       reset;
    logic       x_valid, x_ready, wr_en_x, clear_acc, en_acc, y_valid, y_ready, busy;
    logic [4:0] addr_x;
    logic [1:0] addr_f;
    logic [4:0] y_index;
    logic [2:0] dbg_state;

    logic       x_valid2, x_ready2, wr_en_x2, clear_acc2, en_acc2, y_valid2, y_ready2, busy2;
    logic [1:0] addr_x2;
    logic [1:0] addr_f2;
    logic [0:0] y_index2;
    logic [2:0] dbg_state2;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int ph = -1;
    int cur_base = 0;
    logic [31:0] exp_q[$];

    conv_sched dut (
        .clk(clk), .reset(reset), .x_valid(x_valid), .x_ready(x_ready), .wr_en_x(wr_en_x),
        .addr_x(addr_x), .addr_f(addr_f), .clear_acc(clear_acc), .en_acc(en_acc),
        .y_valid(y_valid), .y_ready(y_ready), .y_index(y_index), .busy(busy),
        .dbg_state(dbg_state)
    );

    conv_sched #(.SIZE_X(4), .SIZE_F(4), .MAC_LAT(3)) dut2 (
        .clk(clk), .reset(reset), .x_valid(x_valid2), .x_ready(x_ready2), .wr_en_x(wr_en_x2),
        .addr_x(addr_x2), .addr_f(addr_f2), .clear_acc(clear_acc2), .en_acc(en_acc2),
        .y_valid(y_valid2), .y_ready(y_ready2), .y_index(y_index2), .busy(busy2),
        .dbg_state(dbg_state2)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Driver tasks
    task automatic push_frame(input int npts);
        for (int i = 0; i < npts; i++) exp_q.push_back(32'(i));
    endtask

    task automatic load_frame(input int n);
        for (int i = 0; i < n; i++) begin
            x_valid = 1'b1;
            chk("load_x_ready", 32'(x_ready), 32'd1);
            tick();
        end
    endtask

    task automatic wait_load_return(input int budget);
        int n;
        n = 0;
        while (!x_ready && n < budget) begin
            tick();
            n++;
        end
        x_valid = 1'b0;
        chk("frame_done_in_budget", 32'(n < budget), 32'd1);
    endtask

    // Scoreboard and per-point sequencing monitor for the default instance
    always @(negedge clk) begin
        if (!reset) begin
            ph = -1;
        end else begin
            chk("wr_en_x_rule", 32'(wr_en_x), 32'(x_valid & x_ready));
            chk("addr_x_range", 32'(addr_x <= 5'd31), 32'd1);
            chk("addr_f_range", 32'(addr_f <= 2'd3), 32'd1);
            if (wr_en_x) begin
                chk("wr_addr_seq", 32'(addr_x), 32'(wr_cnt));
                wr_cnt++;
            end
            if (clear_acc && busy) begin
                ph = 0;
                cur_base = (exp_q.size() > 0) ? int'(exp_q[0]) : 0;
            end else if (ph >= 0) begin
                ph++;
                if (ph <= 8) begin
                    chk("clear_acc_single", 32'(clear_acc), 32'd0);
                    chk("en_acc_window", 32'(en_acc), 32'((ph >= 2) && (ph <= 5)));
                    chk("y_valid_early", 32'(y_valid), 32'd0);
                end
                if (ph <= 4) begin
                    chk("run_addr_f", 32'(addr_f), 32'(ph - 1));
                    chk("run_addr_x", 32'(addr_x), 32'(cur_base + ph - 1));
                end
                if (ph == 9) begin
                    chk("point_latency", 32'(y_valid), 32'd1);
                    ph = -1;
                end
            end
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_point", 32'(y_index), 32'hffff_ffff);
                end else begin
                    chk("y_index_order", 32'(y_index), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int n;
        reset    = 1'b0;
        x_valid  = 1'b0;
        y_ready  = 1'b0;
        x_valid2 = 1'b0;
        y_ready2 = 1'b0;

        // Reset state
        #1;
        chk("rst_x_ready", 32'(x_ready), 32'd1);
        chk("rst_clear_acc", 32'(clear_acc), 32'd1);
        chk("rst_en_acc", 32'(en_acc), 32'd0);
        chk("rst_y_valid", 32'(y_valid), 32'd0);
        chk("rst_y_index", 32'(y_index), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en_lo", 32'(wr_en_x), 32'd0);
        x_valid = 1'b1;
        #1;
        chk("rst_wr_en_hi", 32'(wr_en_x), 32'd1);
        x_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("rel_clear_acc", 32'(clear_acc), 32'd0);
        chk("rel_addr_x", 32'(addr_x), 32'd0);
        tick();
        wr_cnt = 0;

        // Frame A: streaming input and output, nominal latency
        push_frame(29);
        y_ready = 1'b1;
        load_frame(32);
        chk("a_writes", 32'(wr_cnt), 32'd32);
        chk("a_busy_after_load", 32'(busy), 32'd1);
        n = 0;
        while (!y_valid && n < 50) begin
            tick();
            n++;
        end
        chk("a_first_point_edges", 32'(n), 32'd9);
        wait_load_return(29 * 12 + 20);
        chk("a_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("a_y_index_wrap", 32'(y_index), 32'd0);
        chk("a_busy_idle", 32'(busy), 32'd0);

        // Frame B: gappy input, x_valid held in OUT, per-point handshakes with a 20-cycle stall
        wr_cnt = 0;
        push_frame(29);
        y_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            x_valid = (i % 2 == 0);
            tick();
        end
        chk("b_writes", 32'(wr_cnt), 32'd32);
        x_valid = 1'b1;
        for (int p = 0; p < 29; p++) begin
            n = 0;
            while (!y_valid && n < 40) begin
                tick();
                n++;
            end
            chk("b_point_in_budget", 32'(n < 40), 32'd1);
            chk("b_y_index", 32'(y_index), 32'(p));
            chk("b_out_wr_en", 32'(wr_en_x), 32'd0);
            if (p == 5) begin
                for (int s = 0; s < 20; s++) begin
                    chk("stall_y_valid", 32'(y_valid), 32'd1);
                    chk("stall_y_index", 32'(y_index), 32'd5);
                    chk("stall_x_ready", 32'(x_ready), 32'd0);
                    chk("stall_en_acc", 32'(en_acc), 32'd0);
                    chk("stall_clear_acc", 32'(clear_acc), 32'd0);
                    tick();
                end
            end
            y_ready = 1'b1;
            tick();
            y_ready = 1'b0;
        end
        chk("b_x_ready_back", 32'(x_ready), 32'd1);
        x_valid = 1'b0;
        chk("b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Frame C: reset while point 10 is in RUN
        wr_cnt = 0;
        push_frame(29);
        load_frame(32);
        x_valid = 1'b0;
        y_ready = 1'b1;
        n = 0;
        while (!(y_index == 5'd10 && clear_acc && busy) && n < 200) begin
            tick();
            n++;
        end
        chk("c_reach_point10", 32'(n < 200), 32'd1);
        tick();
        tick();
        chk("c_in_run_en_acc", 32'(en_acc), 32'd1);
        reset = 1'b0;
        #1;
        chk("c_rst_x_ready", 32'(x_ready), 32'd1);
        chk("c_rst_y_valid", 32'(y_valid), 32'd0);
        chk("c_rst_y_index", 32'(y_index), 32'd0);
        chk("c_rst_busy", 32'(busy), 32'd0);
        chk("c_rst_en_acc", 32'(en_acc), 32'd0);
        chk("c_rst_addr_x", 32'(addr_x), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        #1;
        chk("c_rel_clear_acc", 32'(clear_acc), 32'd0);
        wr_cnt = 0;

        // Frame D: clean frame after the aborted one
        push_frame(29);
        load_frame(32);
        chk("d_writes", 32'(wr_cnt), 32'd32);
        wait_load_return(29 * 12 + 20);
        chk("d_queue_empty", 32'(exp_q.size()), 32'd0);
        y_ready = 1'b0;

        // SIZE_F == SIZE_X: single point per frame
        for (int i = 0; i < 4; i++) begin
            x_valid2 = 1'b1;
            chk("e_x_ready", 32'(x_ready2), 32'd1);
            chk("e_addr_x", 32'(addr_x2), 32'(i));
            tick();
        end
        x_valid2 = 1'b0;
        n = 0;
        while (!y_valid2 && n < 50) begin
            tick();
            n++;
        end
        chk("e_latency_edges", 32'(n), 32'd9);
        chk("e_y_index", 32'(y_index2), 32'd0);
        y_ready2 = 1'b1;
        tick();
        y_ready2 = 1'b0;
        chk("e_back_to_load", 32'(x_ready2), 32'd1);
        chk("e_y_valid_lo", 32'(y_valid2), 32'd0);
        chk("e_busy_lo", 32'(busy2), 32'd0);

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
